morse_tx_sequencer: RTL and testbench
=====================================

Name: morse_tx_sequencer

Overview:
Controller that queues Morse letters A–H and sequences the 12-bit left-justified pattern shift register that produces DotDashOut. Each symbol bit is held for 0.5 s. A small letter FIFO lets a host strobe in several letters back-to-back. This block replaces the free-running shift/mux glue in the lab5 Morse path and owns all timing: tick divider, bit count, load/shift control, and status.

Parameters:
CLOCK_FREQUENCY, 500, ClockIn rate in Hz; must be even and ≥4; TICK = CLOCK_FREQUENCY/2 cycles per symbol bit.
FIFO_DEPTH, 4, letter queue entries; power of two, ≥2.

Ports:
ClockIn  in  1  system clock, all state on posedge.
Reset  in  1  asynchronous, active-high; clears all state.
Start  in  1  one-cycle push strobe; qualifies Letter.
Letter  in  3  letter code: 0=A … 7=H.
Ready  out  1  FIFO not full (count < FIFO_DEPTH), registered-count based.
Busy  out  1  high in SEND state.
DotDashOut  out  1  current Morse symbol bit.
NewBitOut  out  1  one-cycle pulse in the first cycle each new bit is presented.
LetterDone  out  1  one-cycle pulse when a letter's 12 bits have finished.
Overflow  out  1  sticky; set when Start arrives while Ready=0; cleared only by Reset.

Behaviour:
- Reset (any time, including mid-letter): FIFO empty, state IDLE, tick counter 0, bit count 0, shift reg 0. All outputs 0 except Ready=1.
- Patterns (12 bits, MSB first, left-justified):
  - A 101110000000, B 111010101000, C 111010111010, D 111010100000
  - E 100000000000, F 101011101000, G 111011101000, H 101010100000
- FIFO push: on Start with Ready=1, Letter is written.
- Start with Ready=0 is dropped and sets Overflow, even if a pop occurs that same cycle.
- Push and pop in the same cycle when not full: both occur; count unchanged.
- IDLE: if the FIFO is non-empty at an edge, pop, load the pattern, set bit count 0, clear the tick counter, and go to SEND. A push into an empty FIFO loads on the following edge, so there is 1 cycle of latency from accept to load.
- SEND, with the load at edge e0:
  - Bit k (k=0..11) is visible on DotDashOut during cycles e0+1+k·TICK through e0+(k+1)·TICK.
  - NewBitOut=1 only in the first cycle of each bit.
  - Shift left by one at each TICK boundary; shift in 0.
- End of letter: at edge e0+12·TICK, return to IDLE. For that one cycle DotDashOut=0, Busy=0, LetterDone=1.
- Next letter: if the FIFO is non-empty, the next load is at edge e0+12·TICK+1. Letter-to-letter spacing is therefore exactly 12·TICK+1 cycles; trailing pattern zeros provide the inter-letter gap.
- Tick counter: runs only in SEND; counts 0..TICK-1 and wraps. Bit count wraps 0..11.
- Outputs are registered. DotDashOut = shift_reg[11] while Busy, else 0.

Decomposition:
- Package morse_pkg holds:
  - letter_t (3-bit)
  - PATTERN_W=12
  - localparam array MORSE_PATTERN[8] with the table above
  - state enum {IDLE, SEND}
- Sub-module morse_letter_fifo: parameterised DEPTH, width 3, async reset, push/pop/full/empty/count.
- The shift register and tick counter stay inline in morse_tx_sequencer.

Test Plan:
(All scenarios use CLOCK_FREQUENCY=8, so TICK=4.)
1. Single A: Start, Letter=0 at edge 0 → load at edge 1; DotDashOut sequence 1,0,1,1,1,0… with each bit 4 cycles; 12 NewBitOut pulses; LetterDone pulse at edge 49; Busy low afterward.
2. Back-to-back: push E, H, C on consecutive cycles → letters start 49 cycles apart; per letter, DotDashOut holds "1" for 4 cycles in the E, H, C patterns in order; 3 LetterDone pulses.
3. Overflow: push 5 letters while the first is still being serviced → the 1st is popped, so 4 fit; the 6th Start sees Ready=0 → dropped, Overflow=1 and it stays 1 until Reset.
4. Simultaneous push/pop at full: FIFO full, IDLE pop edge coincides with Start → Start rejected, count drops to 3, Overflow set.
5. Reset mid-letter: assert Reset asynchronously during bit 5 of G → DotDashOut, Busy, NewBitOut, LetterDone drop immediately; FIFO empty; Ready=1; no LetterDone after release.
6. Sweep: push each code 0–7 → captured serial stream equals the MORSE_PATTERN table bit-for-bit.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and Morse pattern table for the Morse transmit sequencer.
// Patterns are 12 bits, MSB sent first, left-justified.
package morse_pkg;

    typedef logic [2:0] letter_t;

    localparam int PATTERN_W = 12;

    localparam logic [PATTERN_W-1:0] MORSE_PATTERN [8] = '{
        12'b101110000000,
        12'b111010101000,
        12'b111010111010,
        12'b111010100000,
        12'b100000000000,
        12'b101011101000,
        12'b111011101000,
        12'b101010100000
    };

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/morse_letter_fifo.sv
// Small letter queue with registered occupancy count.
// Head entry is read combinationally so IDLE can load on the pop edge.
module morse_letter_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  letter_t                din,
    output letter_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    letter_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/morse_tx_sequencer.sv
// Queues Morse letters A-H and serialises their 12-bit patterns,
// holding each symbol bit for TICK = CLOCK_FREQUENCY/2 cycles.
module morse_tx_sequencer
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [2:0] Letter,
    output logic       Ready,
    output logic       Busy,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       LetterDone,
    output logic       Overflow
);

    localparam int TICK = CLOCK_FREQUENCY / 2;
    localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    state_t               state, state_n;
    logic [TW-1:0]        tick, tick_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [PATTERN_W-1:0] shift, shift_n;
    logic                 new_bit_n;
    logic                 done_n;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    letter_t              head;
    logic [CW-1:0]        count;

    assign Ready      = (count < CW'(FIFO_DEPTH));
    assign push       = Start && !full;
    assign Busy       = (state == SEND);
    assign DotDashOut = Busy && shift[PATTERN_W-1];

    morse_letter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ClockIn),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .din   (Letter),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            NewBitOut  <= 1'b0;
            LetterDone <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            NewBitOut  <= new_bit_n;
            LetterDone <= done_n;
            if (Start && !Ready) Overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        new_bit_n = 1'b0;
        done_n    = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_n   = MORSE_PATTERN[head];
                    tick_n    = '0;
                    bit_cnt_n = '0;
                    new_bit_n = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (tick == TW'(TICK - 1)) begin
                    tick_n  = '0;
                    shift_n = shift << 1;
                    // Last bit boundary ends the letter instead of starting a new bit.
                    if (bit_cnt == 4'd11) begin
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        new_bit_n = 1'b1;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer with CLOCK_FREQUENCY=8 (TICK=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_morse_tx_sequencer;

    logic       ClockIn;
    logic       Reset;
    logic       Start;
    logic [2:0] Letter;
    logic       Ready;
    logic       Busy;
    logic       DotDashOut;
    logic       NewBitOut;
    logic       LetterDone;
    logic       Overflow;

    int errors = 0;
    int checks = 0;

    logic [11:0] pat [8] = '{
        12'b101110000000,
        12'b111010101000,
        12'b111010111010,
        12'b111010100000,
        12'b100000000000,
        12'b101011101000,
        12'b111011101000,
        12'b101010100000
    };

    morse_tx_sequencer #(
        .CLOCK_FREQUENCY (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .Start      (Start),
        .Letter     (Letter),
        .Ready      (Ready),
        .Busy       (Busy),
        .DotDashOut (DotDashOut),
        .NewBitOut  (NewBitOut),
        .LetterDone (LetterDone),
        .Overflow   (Overflow)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic check_cycle(input int code, input int i);
        int k;
        int c;
        k = i / 4;
        c = i % 4;
        chk("dot_dash", 12'(DotDashOut), 12'(pat[code][11-k]));
        chk("new_bit", 12'(NewBitOut), (c == 0) ? 12'd1 : 12'd0);
        if (c == 0) chk("busy", 12'(Busy), 12'd1);
    endtask

    // Entered at cycle index 'first' after the load edge; leaves at the LetterDone edge.
    task automatic run_letter(input int code, input int first);
        for (int i = first; i < 48; i++) begin
            check_cycle(code, i);
            step();
        end
        chk("letter_done", 12'(LetterDone), 12'd1);
        chk("end_busy", 12'(Busy), 12'd0);
        chk("end_dot_dash", 12'(DotDashOut), 12'd0);
    endtask

    initial begin
        logic [11:0] cap;
        logic        seen;
        Reset  = 1'b1;
        Start  = 1'b0;
        Letter = 3'd0;
        #12;
        chk("rst_ready", 12'(Ready), 12'd1);
        chk("rst_busy", 12'(Busy), 12'd0);
        chk("rst_dot_dash", 12'(DotDashOut), 12'd0);
        chk("rst_new_bit", 12'(NewBitOut), 12'd0);
        chk("rst_done", 12'(LetterDone), 12'd0);
        chk("rst_overflow", 12'(Overflow), 12'd0);
        step();
        Reset = 1'b0;
        step();

        // Single A
        Start  = 1'b1;
        Letter = 3'd0;
        step();
        Start = 1'b0;
        chk("a_ready", 12'(Ready), 12'd1);
        chk("a_pre_busy", 12'(Busy), 12'd0);
        step();
        run_letter(0, 0);
        step();
        chk("a_done_pulse", 12'(LetterDone), 12'd0);
        chk("a_idle_busy", 12'(Busy), 12'd0);

        // Back-to-back E, H, C
        Start  = 1'b1;
        Letter = 3'd4;
        step();
        Letter = 3'd7;
        step();
        check_cycle(4, 0);
        Letter = 3'd2;
        step();
        Start = 1'b0;
        run_letter(4, 1);
        step();
        run_letter(7, 0);
        step();
        run_letter(2, 0);
        step();
        chk("b2b_idle_busy", 12'(Busy), 12'd0);
        chk("b2b_done_pulse", 12'(LetterDone), 12'd0);

        // Overflow: B loads, D F G A fill the queue, H is dropped
        Start  = 1'b1;
        Letter = 3'd1;
        step();
        Letter = 3'd3;
        step();
        Letter = 3'd5;
        step();
        Letter = 3'd6;
        step();
        Letter = 3'd0;
        step();
        chk("ovf_full_ready", 12'(Ready), 12'd0);
        chk("ovf_not_yet", 12'(Overflow), 12'd0);
        Letter = 3'd7;
        step();
        Start = 1'b0;
        chk("ovf_set", 12'(Overflow), 12'd1);
        chk("ovf_ready", 12'(Ready), 12'd0);
        run_letter(1, 4);
        step();
        run_letter(3, 0);
        step();
        run_letter(5, 0);
        step();
        run_letter(6, 0);
        step();
        run_letter(0, 0);
        step();
        chk("ovf_dropped", 12'(Busy), 12'd0);
        chk("ovf_sticky", 12'(Overflow), 12'd1);

        // Push rejected on the same edge as a pop from a full queue
        Reset = 1'b1;
        #2;
        chk("rst2_overflow", 12'(Overflow), 12'd0);
        chk("rst2_ready", 12'(Ready), 12'd1);
        step();
        Reset = 1'b0;
        step();
        Start  = 1'b1;
        Letter = 3'd2;
        step();
        Letter = 3'd4;
        step();
        Letter = 3'd1;
        step();
        Letter = 3'd0;
        step();
        Letter = 3'd3;
        step();
        Start = 1'b0;
        chk("pp_full", 12'(Ready), 12'd0);
        run_letter(2, 3);
        Start  = 1'b1;
        Letter = 3'd7;
        step();
        Start = 1'b0;
        chk("pp_overflow", 12'(Overflow), 12'd1);
        chk("pp_ready", 12'(Ready), 12'd1);
        chk("pp_load_busy", 12'(Busy), 12'd1);
        chk("pp_load_dd", 12'(DotDashOut), 12'd1);
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("pp_refill", 12'(Ready), 12'd0);

        // Reset during bit 5 of G
        Reset = 1'b1;
        #2;
        step();
        Reset = 1'b0;
        step();
        Start  = 1'b1;
        Letter = 3'd6;
        step();
        Start = 1'b0;
        step();
        repeat (20) step();
        chk("g_bit5_dd", 12'(DotDashOut), 12'd1);
        chk("g_bit5_nb", 12'(NewBitOut), 12'd1);
        Reset = 1'b1;
        #1;
        chk("mid_rst_dd", 12'(DotDashOut), 12'd0);
        chk("mid_rst_busy", 12'(Busy), 12'd0);
        chk("mid_rst_nb", 12'(NewBitOut), 12'd0);
        chk("mid_rst_done", 12'(LetterDone), 12'd0);
        chk("mid_rst_ready", 12'(Ready), 12'd1);
        step();
        step();
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (Busy || LetterDone || DotDashOut) seen = 1'b1;
        end
        chk("post_rst_quiet", 12'(seen), 12'd0);

        // Sweep all eight letters
        for (int code = 0; code < 8; code++) begin
            Start  = 1'b1;
            Letter = 3'(code);
            step();
            Start = 1'b0;
            step();
            cap = '0;
            for (int i = 0; i < 48; i++) begin
                if (i % 4 == 2) cap = {cap[10:0], DotDashOut};
                step();
            end
            chk("sweep_pattern", cap, pat[code]);
            chk("sweep_done", 12'(LetterDone), 12'd1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
